// File: rtl/fm_mod.sv
// FM modulator: phase accumulator steered by fc_word + sample*kf, driving a sine table.
// Modulation samples are accepted once every DIV clocks; a missed sample raises a sticky underrun flag.
module fm_mod #(
  parameter int DIV     = 50,
  parameter int PHASE_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [PHASE_W-1:0] fc_word,
  input  logic [15:0]        kf,
  input  logic [9:0]         mod_data,
  input  logic               mod_valid,
  output logic               mod_ready,
  output logic [9:0]         mod_out,
  output logic               out_valid,
  output logic               underrun
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   count;
  logic               tick;
  logic [9:0]         sample;
  logic [PHASE_W-1:0] freq;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] s_ext;
  logic [PHASE_W-1:0] freq_calc;
  logic signed [9:0]  lut_q;
  logic               lut_valid;

  // Full-wave sine table, elaborated from real math so no hand-typed constants are needed.
  logic signed [9:0] sine_rom [1024];
  for (genvar k = 0; k < 1024; k++) begin : g_rom
    localparam real VAL = 511.0 * $sin(2.0 * 3.141592653589793 * k / 1024.0);
    localparam int  ENT = (VAL >= 0.0) ? $rtoi(VAL + 0.5) : -$rtoi(0.5 - VAL);
    assign sine_rom[k] = ENT[9:0];
  end

  assign tick = (count == CNT_W'(DIV - 1));

  // Unmodulated mode zeroes the sample; the unsigned product wraps like a two's complement one.
  assign s_ext     = mode ? '0 : {{(PHASE_W-10){sample[9]}}, sample};
  assign freq_calc = fc_word + s_ext * PHASE_W'(kf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mod_ready = 1'b0;
    case (state)
      IDLE: if (en) state_nxt = RUN;
      RUN: begin
        if (!en) state_nxt = IDLE;
        mod_ready = tick;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // freq is preloaded on the entry edge so the first RUN cycle sits at phase 0 and the next advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      sample    <= '0;
      freq      <= '0;
      phase     <= '0;
      lut_q     <= '0;
      lut_valid <= 1'b0;
      mod_out   <= 10'd512;
      out_valid <= 1'b0;
      underrun  <= 1'b0;
    end else if (state == IDLE) begin
      count     <= '0;
      sample    <= '0;
      freq      <= en ? freq_calc : '0;
      phase     <= '0;
      lut_q     <= '0;
      lut_valid <= 1'b0;
      mod_out   <= 10'd512;
      out_valid <= 1'b0;
    end else if (!en) begin
      count     <= '0;
      sample    <= '0;
      freq      <= '0;
      phase     <= '0;
      lut_q     <= '0;
      lut_valid <= 1'b0;
      mod_out   <= 10'd512;
      out_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      count <= tick ? '0 : count + 1'b1;
      if (tick) begin
        if (mod_valid) sample   <= mod_data;
        else           underrun <= 1'b1;
      end
      freq      <= freq_calc;
      phase     <= phase + freq;
      lut_q     <= sine_rom[phase[PHASE_W-1 -: 10]];
      lut_valid <= 1'b1;
      // Adding 512 to a 10-bit signed value is just an MSB flip.
      mod_out   <= {~lut_q[9], lut_q[8:0]};
      out_valid <= lut_valid;
    end
  end

endmodule

// File: tb/tb_fm_mod.sv
// Self-checking bench for fm_mod: a cycle-indexed phase-history model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fm_mod;

  localparam int DIV = 4;
  localparam int PW  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          mode = 1'b0;
  logic [PW-1:0] fc_word = '0;
  logic [15:0]   kf = '0;
  logic [9:0]    mod_data = '0;
  logic          mod_valid = 1'b0;
  logic          mod_ready;
  logic [9:0]    mod_out;
  logic          out_valid;
  logic          underrun;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Model: m_n counts cycles since RUN entry; hist[n] is the phase expected during cycle n.
  bit            m_run = 1'b0;
  int            m_n = 0;
  logic [9:0]    m_sample = '0;
  bit            m_under = 1'b0;
  logic [PW-1:0] m_freq = '0;
  logic [PW-1:0] hist[$];

  fm_mod #(.DIV(DIV), .PHASE_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .fc_word(fc_word), .kf(kf),
    .mod_data(mod_data), .mod_valid(mod_valid), .mod_ready(mod_ready),
    .mod_out(mod_out), .out_valid(out_valid), .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic int sine_ref(input int k);
    real v;
    v = 511.0 * $sin(2.0 * 3.141592653589793 * k / 1024.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic m, input logic [31:0] fc,
                               input logic [15:0] k, input logic [9:0] d, input logic v);
    en = e; mode = m; fc_word = fc; kf = k; mod_data = d; mod_valid = v;
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitValid(input string name);
    int waited;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checkOutput(name, 32'(out_valid), 32'd1);
  endtask

  // Model update on each active edge (or asynchronous reset).
  initial begin
    int            s;
    logic [PW-1:0] nf;
    logic [PW-1:0] np;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_run = 1'b0; m_under = 1'b0; m_sample = '0;
      end else if (!m_run) begin
        if (en) begin
          m_run = 1'b1; m_n = 0; m_sample = '0; m_freq = fc_word;
          hist.delete();
          hist.push_back('0);
        end
      end else if (!en) begin
        m_run = 1'b0; m_under = 1'b0;
      end else begin
        s  = mode ? 0 : int'($signed(m_sample));
        nf = 32'(longint'(fc_word) + longint'(s) * longint'(kf));
        if (m_n % DIV == DIV - 1) begin
          if (mod_valid) m_sample = mod_data;
          else           m_under  = 1'b1;
        end
        np = hist[m_n] + m_freq;
        hist.push_back(np);
        m_freq = nf;
        m_n++;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    bit            ev;
    logic [PW-1:0] ph;
    logic [9:0]    eo;
    forever begin
      @(negedge clk);
      if (chk_en && rst_n) begin
        ev = m_run && (m_n >= 2);
        eo = 10'd512;
        if (ev) begin
          ph = hist[m_n - 2];
          eo = 10'(512 + sine_ref(int'(ph[PW-1 -: 10])));
        end
        checkOutput("out_valid", 32'(out_valid), 32'(ev));
        checkOutput("mod_out", 32'(mod_out), 32'(eo));
        checkOutput("mod_ready", 32'(mod_ready), 32'(m_run && (m_n % DIV == DIV - 1)));
        checkOutput("underrun", 32'(underrun), 32'(m_under));
      end
    end
  end

  initial begin
    int ref34[17] = '{512, 708, 873, 984, 1023, 984, 873, 708, 512, 316, 151, 40, 1, 40, 151, 316, 512};

    runCycles(2);
    checkOutput("rst_mod_out", 32'(mod_out), 32'd512);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_underrun", 32'(underrun), 32'd0);
    checkOutput("rst_mod_ready", 32'(mod_ready), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    runCycles(2);

    // Unmodulated carrier, period-16 sine
    applyStimulus(1'b1, 1'b1, 32'h1000_0000, 16'h0000, 10'd0, 1'b0);
    waitValid("carrier_valid_rise");
    for (int i = 0; i < 17; i++) begin
      checkOutput("carrier_seq", 32'(mod_out), 32'(ref34[i]));
      @(negedge clk);
    end
    applyStimulus(1'b0, 1'b0, 32'h1000_0000, 16'h0000, 10'd0, 1'b0);
    runCycles(2);

    // FM with sample 100, kf 0x100
    applyStimulus(1'b1, 1'b0, 32'h1000_0000, 16'h0100, 10'd100, 1'b1);
    @(negedge clk);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 3) checkOutput("fm_tick_ready", 32'(mod_ready), 32'd1);
      if (n == 4) checkOutput("fm_freq_before", dut.freq, 32'h1000_0000);
      if (n == 5) checkOutput("fm_freq_after", dut.freq, 32'h1000_6400);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h1000_0000, 16'hFFFF, 10'(i * 97 - 400), 1'b1);
      runCycles(DIV);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 16'h0, 10'd0, 1'b0);
    runCycles(2);

    // Negative-frequency wrap
    applyStimulus(1'b1, 1'b0, 32'h0, 16'hFFFF, 10'h200, 1'b1);
    @(negedge clk);
    runCycles(4);
    checkOutput("wrap_freq_pre", dut.freq, 32'h0);
    @(negedge clk);
    checkOutput("wrap_freq", dut.freq, 32'hFE00_0200);
    runCycles(30);
    applyStimulus(1'b0, 1'b0, 32'h0, 16'h0, 10'd0, 1'b0);
    runCycles(2);

    // Underrun: sample held, flag sticky until en drops
    applyStimulus(1'b1, 1'b0, 32'h0800_0000, 16'hFFFF, 10'd50, 1'b1);
    runCycles(6);
    applyStimulus(1'b1, 1'b0, 32'h0800_0000, 16'hFFFF, 10'h3F9, 1'b0);
    runCycles(8);
    checkOutput("underrun_set", 32'(underrun), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0800_0000, 16'hFFFF, 10'h3F9, 1'b0);
    @(negedge clk);
    checkOutput("underrun_clear", 32'(underrun), 32'd0);
    runCycles(1);

    // en dropped on a tick cycle, then restarted
    applyStimulus(1'b1, 1'b0, 32'h1000_0000, 16'hFFFF, 10'd20, 1'b1);
    runCycles(4);
    checkOutput("drop_on_tick_ready", 32'(mod_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h1000_0000, 16'hFFFF, 10'd300, 1'b1);
    @(negedge clk);
    checkOutput("drop_out_valid", 32'(out_valid), 32'd0);
    checkOutput("drop_underrun", 32'(underrun), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h1000_0000, 16'hFFFF, 10'd300, 1'b1);
    waitValid("restart_valid_rise");
    checkOutput("restart_first_out", 32'(mod_out), 32'd512);
    runCycles(8);
    applyStimulus(1'b0, 1'b0, 32'h0, 16'h0, 10'd0, 1'b0);
    runCycles(2);

    // Asynchronous reset mid-RUN
    applyStimulus(1'b1, 1'b0, 32'h0300_0000, 16'h0400, 10'd0, 1'b0);
    runCycles(8);
    checkOutput("pre_reset_underrun", 32'(underrun), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_mod_out", 32'(mod_out), 32'd512);
    checkOutput("async_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_underrun", 32'(underrun), 32'd0);
    checkOutput("async_mod_ready", 32'(mod_ready), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    waitValid("resume_valid_rise");
    checkOutput("resume_first_out", 32'(mod_out), 32'd512);
    runCycles(10);
    applyStimulus(1'b0, 1'b0, 32'h0, 16'h0, 10'd0, 1'b0);
    runCycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fm_mod.md
FM_MOD -- requirements
Module: fm_mod

Interface
REQ-001 SHALL have parameter DIV, default 50: clk cycles per modulation-sample tick, legal range 2..65535.
REQ-002 SHALL have parameter PHASE_W, default 32: phase accumulator and frequency word width.
REQ-003 SHALL use reset rst_n, asynchronous, active-low; clock clk.
REQ-004 clk  input  1  system clock, all logic rising-edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 en  input  1  run enable; high = modulate, low = idle.
REQ-007 mode  input  1  0 = FM, 1 = unmodulated carrier (modulation sample forced to 0).
REQ-008 fc_word  input  PHASE_W  carrier frequency word, unsigned.
REQ-009 kf  input  16  deviation gain, unsigned, frequency-word LSBs per modulation LSB.
REQ-010 mod_data  input  10  modulation sample, two's complement.
REQ-011 mod_valid  input  1  mod_data valid.
REQ-012 mod_ready  output  1  block accepts mod_data this cycle.
REQ-013 mod_out  output  10  FM waveform, offset binary (512 = zero).
REQ-014 out_valid  output  1  mod_out valid.
REQ-015 underrun  output  1  sticky: tick occurred without mod_valid.

Function
REQ-016 SHALL implement FSM with states IDLE and RUN: IDLE->RUN on edge with en=1; RUN->IDLE on edge with en=0; no other states.
REQ-017 SHALL, in IDLE, hold phase accumulator, tick counter, sample register and frequency register at 0, out_valid=0 and mod_out=512.
REQ-018 SHALL run tick counter 0..DIV-1 in RUN, starting at 0 on the first RUN cycle, wrapping to 0; tick = (count == DIV-1).
REQ-019 SHALL drive mod_ready = 1 only in RUN on tick cycles, combinationally from state and count.
REQ-020 SHALL latch mod_data into sample register on tick when mod_valid=1; on tick with mod_valid=0, SHALL hold the previous sample and set underrun.
REQ-021 SHALL treat mod_valid outside tick cycles as not accepted (no latch, no flag).
REQ-022 SHALL clear underrun only by reset or by the RUN->IDLE transition.
REQ-023 SHALL compute the effective sample s = (mode ? 0 : sample register), sign-extended.
REQ-024 SHALL register freq = fc_word + s*kf, modulo 2^PHASE_W (two's complement, wrap, no saturation), and update it every RUN cycle.
REQ-025 SHALL add freq to phase every RUN cycle, modulo 2^PHASE_W; the first RUN cycle adds 0.
REQ-026 SHALL take fc_word, kf and mode changes into freq within 1 cycle; a sample latched at edge T SHALL reach freq at edge T+1 and first affect phase at edge T+2.
REQ-027 SHALL address a 1024-entry sine table with phase[PHASE_W-1:PHASE_W-10]; entry k = round(511*sin(2*pi*k/1024)), signed 10-bit. Quarter-wave compression is allowed if the outputs are bit-exact.
REQ-028 SHALL output mod_out = entry + 512, range 1..1023, with 2 register stages after the phase register: out_valid=1 starting 2 cycles after RUN entry.
REQ-029 SHALL, on RUN->IDLE, drop out_valid and force mod_out=512 at the same edge, discarding in-flight pipeline data.
REQ-030 SHALL give en deassert priority over a coincident tick: no latch and no underrun on that edge.
REQ-031 SHALL make the output sequence depend only on inputs since the last IDLE, so re-entering RUN restarts phase from 0.

Reset
REQ-032 SHALL, on rst_n low, asynchronously force IDLE, all counters and registers 0, mod_out=512, out_valid=0, underrun=0.
REQ-033 SHALL, after rst_n rises, need en sampled high before leaving IDLE; reset mid-RUN SHALL abort immediately with no residual output.

Verification
REQ-034 mode=1, fc_word=0x10000000, kf=0, en high -> after out_valid rises, mod_out = 512,708,873,984,1023,984,873,708,512,316,151,40,1,... with period 16.
REQ-035 mode=0, fc_word=0x10000000, kf=0x0100, DIV=4, mod_data=100 valid every tick -> freq = 0x10006400 from edge T+1 after the first accepted tick; phase increments match exactly.
REQ-036 mod_data=-512, kf=0xFFFF, fc_word=0 -> freq = 0xFE000200 (wrap); output is a valid negative-frequency sine with no X values.
REQ-037 mod_valid held low through a tick -> underrun=1 and stays 1 while RUN; sample held; en low clears it.
REQ-038 en dropped on a tick cycle, then reasserted -> no latch, out_valid low for at least 1 cycle, phase restarts at 0, first output 512.
REQ-039 rst_n pulsed low mid-RUN (asynchronously, between clk edges) -> outputs immediately 512/0/0, mod_ready=0, and RUN resumes cleanly on en.
